cache_fill_server: RTL
======================

# cache_fill_server

Memory-side responder for the two-way cache's line-fill handshake. It accepts a level `sdram_req` and issues one 8-word burst read to the SDRAM controller's burst port, which returns words in linear order, possibly with gaps. It collects the line into an 8-entry buffer and replays it to the cache critical-word-first as an unbroken 8-cycle stream headed by a one-cycle `sdram_fill` strobe.

## Interface
- `ADDR_BITS`, 26, byte-address width; bit 0 ignored, bits [3:1] select the word in the line.
- `clk`  in  1  system clock; single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sdram_req`  in  1  cache fill request; level, held until `sdram_fill` is seen.
- `req_addr`  in  ADDR_BITS  byte address of the missing word; valid while `sdram_req` is high.
- `sdram_fill`  out  1  one-cycle strobe marking the first (critical) word.
- `data_from_sdram`  out  16  fill data to the cache, registered.
- `mem_req`  out  1  burst request to the SDRAM controller.
- `mem_addr`  out  ADDR_BITS-4  line address, `req_addr[ADDR_BITS-1:4]`.
- `mem_ack`  in  1  controller has accepted the request.
- `mem_valid`  in  1  `mem_data` holds the next line word (order: word 0 to word 7).
- `mem_data`  in  16  returned word.

## Operation
- States: IDLE, REQ, COLLECT, STREAM.
- **IDLE**
  - If `sdram_req`=1: latch `mem_addr` and crit = `req_addr[3:1]`; set `mem_req`=1; clear the word counter; go to REQ.
- **REQ**
  - Hold `mem_req` until `mem_ack`=1.
  - On ack: `mem_req`=0 the next cycle; go to COLLECT.
  - A `mem_valid` in the ack cycle is counted.
- **COLLECT**
  - Each `mem_valid` writes `mem_data` to buffer[count], then count++ (3-bit).
  - On the 8th valid: load rd_idx = crit; go to STREAM.
- **STREAM**, 8 cycles k=0..7:
  - `data_from_sdram` = buffer[(crit+k) mod 8].
  - `sdram_fill`=1 only at k=0.
  - After k=7: drive `data_from_sdram` to 0 and go to IDLE.
- Wrap-around: the read index is a 3-bit add, so it wraps naturally (crit=5 streams 5,6,7,0,1,2,3,4).
- Ignored inputs:
  - `mem_valid` in IDLE, in REQ without ack, or in STREAM.
  - Any valid beyond the 8th.
  - `mem_ack` outside REQ.
- `sdram_req` is not sampled outside IDLE.
  - The cache drops req the cycle after `sdram_fill`, so no retrigger occurs.
  - A req still high on return to IDLE is served as a new request.
- Read-only block; cache writes do not pass through it.
- Reset (any time, including mid-burst):
  - Immediately: `mem_req`=0, `sdram_fill`=0, `data_from_sdram`=0, state=IDLE, count=0.
  - Buffer contents are not cleared.
  - A controller burst in flight at reset is the controller's responsibility; its late valids arrive in IDLE and are ignored.

## Timing
- Reset values: all outputs 0; `mem_addr` 0.
- `sdram_req` sampled high in IDLE at cycle N → `mem_req`=1 at N+1.
- `mem_ack` at cycle A → `mem_req`=0 at A+1.
- 8th `mem_valid` at cycle V:
  - `sdram_fill`=1 with the critical word at V+1.
  - Words 2..8 at V+2..V+8, no gaps.
  - IDLE at V+9.
- Minimum turnaround: a new request sampled at V+9 gives `mem_req` at V+10.
- Best-case miss latency (ack at N+1, 8 back-to-back valids starting at N+1): `sdram_fill` at N+9.
- `data_from_sdram` is registered; no combinational path from `mem_*` to cache outputs.

## Structure
- Shared package `cache_fill_pkg`:
  - `LINE_WORDS`=8, `WORD_IDX_BITS`=3.
  - State enum / localparams IDLE=0, REQ=1, COLLECT=2, STREAM=3.
  - Shared with the cache for line geometry.
- Sub-module `fill_line_buffer`: 8×16 register file with one write port (index, enable) and one registered read port (index). The FSM, counter, crit latch and handshake stay in the top level.

## Test plan
- Reset check: hold `reset_n`=0 with `mem_valid`/`mem_ack` toggling → all outputs 0, no `mem_req`; release → IDLE, outputs remain 0.
- Aligned fill: `req_addr`=0x000_1230 (crit 0), ack next cycle, valids carrying 0x1000..0x1007 back-to-back → `mem_addr`=0x00_0123; `sdram_fill` one cycle with 0x1000, then 0x1001..0x1007 on consecutive cycles; exactly one fill pulse.
- Critical-word wrap: `req_addr`=0x000_123A (crit 5), same data → stream 0x1005,0x1006,0x1007,0x1000,0x1001,0x1002,0x1003,0x1004.
- Stalls: ack 3 cycles late, 2-cycle gaps between valids → `mem_req` held exactly until ack; `sdram_fill` exactly one cycle after the 8th valid; stream still gapless.
- Reset mid-COLLECT: after 4 valids, pulse `reset_n` low asynchronously (off-edge) → outputs 0 immediately. A new request crit 2 with data 0x2000..0x2007 then streams 0x2002..0x2001 correctly; no stale count carried over.
- Stray traffic: `mem_valid` pulses in IDLE and a 9th valid after COLLECT completes → ignored; buffer and stream unaffected; `sdram_req` still high on return to IDLE produces a second `mem_req`.

Source files
------------

// File: rtl/cache_fill_pkg.sv
// cache_fill_pkg: line geometry and fill FSM states
// shared by the cache and its memory-side fill server
package cache_fill_pkg;

  localparam int LINE_WORDS    = 8;
  localparam int WORD_IDX_BITS = 3;
  localparam int WORD_BITS     = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    COLLECT = 2'd2,
    STREAM  = 2'd3
  } fill_state_t;

endpackage

// File: rtl/fill_line_buffer.sv
// fill_line_buffer: 8x16 line store, one write port and
// one registered read port (re=0 drives the read register to 0)
module fill_line_buffer
  import cache_fill_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     we,
  input  logic [WORD_IDX_BITS-1:0] waddr,
  input  logic [WORD_BITS-1:0]     wdata,
  input  logic                     re,
  input  logic [WORD_IDX_BITS-1:0] raddr,
  output logic [WORD_BITS-1:0]     rdata
);

  logic [WORD_BITS-1:0] mem [LINE_WORDS];

  // contents survive reset on purpose
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // write-first forwarding: the last word of a line may
  // be the critical word read in the same cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      rdata <= '0;
    else if (!re)
      rdata <= '0;
    else if (we && (waddr == raddr))
      rdata <= wdata;
    else
      rdata <= mem[raddr];
  end

endmodule

// File: rtl/cache_fill_server.sv
// cache_fill_server: one 8-word burst per cache miss, replayed
// critical-word-first. Ports: cache side (sdram_req, req_addr,
// sdram_fill, data_from_sdram), controller side (mem_*).
module cache_fill_server
  import cache_fill_pkg::*;
#(
  parameter int ADDR_BITS = 26
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sdram_req,
  input  logic [ADDR_BITS-1:0] req_addr,
  output logic                 sdram_fill,
  output logic [WORD_BITS-1:0] data_from_sdram,
  output logic                 mem_req,
  output logic [ADDR_BITS-5:0] mem_addr,
  input  logic                 mem_ack,
  input  logic                 mem_valid,
  input  logic [WORD_BITS-1:0] mem_data
);

  fill_state_t state;

  logic [WORD_IDX_BITS-1:0] count;
  logic [WORD_IDX_BITS-1:0] crit;
  logic [WORD_IDX_BITS-1:0] rd_idx;
  logic [WORD_IDX_BITS-1:0] raddr;
  logic                     take;
  logic                     last;
  logic                     re;
  logic                     unused_bit0;

  assign unused_bit0 = req_addr[0];

  // count doubles as the stream beat k; it wraps 7->0
  // on the last valid, so STREAM starts at k=0
  always_comb begin
    take = 1'b0;
    if (mem_valid) begin
      take = (state == COLLECT) ||
             ((state == REQ) && mem_ack);
    end
    last  = take && (state == COLLECT) &&
            (count == 3'd7);
    re    = last ||
            ((state == STREAM) && (count != 3'd7));
    raddr = (state == STREAM) ? rd_idx + 3'd1 : crit;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      count      <= '0;
      crit       <= '0;
      rd_idx     <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      sdram_fill <= 1'b0;
    end else begin
      sdram_fill <= last;
      unique case (state)
        IDLE: begin
          if (sdram_req) begin
            mem_addr <= req_addr[ADDR_BITS-1:4];
            crit     <= req_addr[3:1];
            mem_req  <= 1'b1;
            count    <= '0;
            state    <= REQ;
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= COLLECT;
            if (take) count <= count + 3'd1;
          end
        end
        COLLECT: begin
          if (take) begin
            count <= count + 3'd1;
            if (count == 3'd7) begin
              rd_idx <= crit;
              state  <= STREAM;
            end
          end
        end
        STREAM: begin
          count  <= count + 3'd1;
          rd_idx <= rd_idx + 3'd1;
          if (count == 3'd7) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  fill_line_buffer u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (take),
    .waddr   (count),
    .wdata   (mem_data),
    .re      (re),
    .raddr   (raddr),
    .rdata   (data_from_sdram)
  );

endmodule
